tsc_multicycle_control: RTL and testbench
=========================================

Name: tsc_multicycle_control

Overview:
- Multicycle control FSM for the 16-bit TSC datapath.
- Sequences each instruction through IF/ID/EX/MEM/WB.
- Drives every datapath mux and enable, plus the 1-bit ALUOp consumed by the ALU control unit.
- Stalls on a single-port memory ready handshake and tracks halt and retired-instruction count.

Parameters:
- WORD_W, 16, datapath/counter width
- NUM_INST_W, 16, width of retired-instruction counter

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- opcode  input  4  IR[15:12]
- funct  input  6  IR[5:0]
- input_ready  input  1  memory ack: read data valid / write accepted this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if branch condition true (condition from ALU, branchType path)
- i_or_d  output  1  0=PC addresses memory, 1=ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load
- reg_write  output  1  register file write
- mem_to_reg  output  1  1=MDR to RF, 0=ALUOut
- reg_dst  output  2  00=rt, 01=rd, 10=$2
- alu_op  output  1  ALUOp to ALU control (1=compute, 0=branch compare)
- alu_src_a  output  1  0=PC, 1=rs
- alu_src_b  output  2  00=rt, 01=const 1, 10=sign/zero imm, 11=branch offset
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target, 11=rs
- output_port  output  1  WWD: latch rs to output port
- is_halted  output  1  sticky after HLT
- num_inst  output  NUM_INST_W  retired instruction count

Behaviour:
- States: S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT.
- Outputs are Moore/Mealy on state plus decoded opcode/funct/input_ready. Any output not listed for a state is 0.
- Reset, checked first every cycle, including mid-instruction or in S_HALT:
  - state=S_IF, num_inst=0, is_halted=0.
  - Same cycle: all strobes 0 regardless of state.
- S_IF: i_or_d=0, mem_read=1. Hold while input_ready=0.
  - When input_ready=1 (single cycle): ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, pc_source=00 (PC<=PC+1), then go to S_ID.
- S_ID: ALU precomputes branch target (alu_src_a=0, alu_src_b=11) into ALUOut.
  - HLT (ALU_OP, funct 29) -> S_HALT.
  - JMP (9): pc_write=1, pc_source=10 -> S_IF.
  - JAL (10): pc_write=1, pc_source=10, reg_write=1, reg_dst=10 -> S_IF.
  - Else -> S_EX.
- S_EX: alu_op=1, alu_src_a=1, alu_src_b=00 for ALU_OP, 10 for immediate/memory types.
  - R-type arith/logic, ADI(4)/ORI(5)/LHI(6) -> S_WB.
  - LWD(7)/SWD(8) -> S_MEM.
  - WWD (funct 28): output_port=1 -> S_IF.
  - JPR (funct 25): pc_write=1, pc_source=11 -> S_IF.
  - JRL (funct 26): as JPR plus reg_write=1, reg_dst=10 -> S_IF.
  - Branch BNE/BEQ/BGZ/BLZ (0-3): alu_op=0, alu_src_b=00, pc_write_cond=1, pc_source=01 -> S_IF.
  - Undefined opcode/funct: no strobes -> S_IF.
- S_MEM: i_or_d=1, with mem_read=1 (LWD) or mem_write=1 (SWD), held until input_ready=1.
  - On ready: LWD -> S_WB, SWD -> S_IF.
- S_WB: reg_write=1.
  - R-type: reg_dst=01, mem_to_reg=0.
  - ADI/ORI/LHI: reg_dst=00, mem_to_reg=0.
  - LWD: reg_dst=00, mem_to_reg=1.
  - -> S_IF.
- Retirement: num_inst increments by 1 on every transition into S_IF from S_ID/S_EX/S_MEM/S_WB. Wraps modulo 2^NUM_INST_W. HLT does not count.
- S_HALT: is_halted=1, all strobes 0, state held until reset.
- Memory handshake: mem_read/mem_write stay asserted with constant i_or_d for the full wait. input_ready outside S_IF/S_MEM is ignored.
- Latency, zero-wait memory: R-type/imm 4 cycles, LWD 5, SWD 4, branch/JPR/JRL/WWD 3, JMP/JAL 2.

Decomposition:
- Opcodes, funct codes and state encodings belong in the shared opcodes.v include; add state and mux-select localparams there.
- One natural sub-module: tsc_inst_decode, combinational opcode/funct to instruction-class flags (is_rtype, is_imm, is_load, is_store, is_branch, is_jump, is_jal, is_jpr, is_jrl, is_wwd, is_hlt).
- FSM, counter and output logic stay in tsc_multicycle_control.

Test Plan:
- ADD (op 15, funct 0), input_ready=1 in IF -> states IF,ID,EX,WB,IF; WB cycle reg_write=1, reg_dst=01; num_inst 0->1.
- LWD with input_ready low 3 cycles in MEM -> mem_read=1, i_or_d=1 held 4 cycles; WB mem_to_reg=1; total 8 cycles.
- BEQ (op 1) -> EX cycle alu_op=0, pc_write_cond=1, pc_source=01; back to IF after 3 cycles.
- JAL (op 10) -> ID cycle pc_write=1, pc_source=10, reg_write=1, reg_dst=10; 2 cycles total.
- HLT (funct 29) -> S_HALT; is_halted=1, strobes 0 for 20 cycles; num_inst unchanged; reset -> is_halted=0, num_inst=0, IF.
- Reset asserted during S_MEM of SWD -> next cycle S_IF, mem_write=0, num_inst=0.

Source files
------------

// File: rtl/tsc_multicycle_control_pkg.sv
// Shared encodings for the TSC multicycle controller: opcodes, funct codes,
// FSM states, datapath mux selects and the decoded instruction-class bundle.
package tsc_multicycle_control_pkg;

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_BGZ = 4'd2;
    localparam logic [3:0] OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_ALU = 4'd15;

    localparam logic [5:0] FN_ADD = 6'd0;
    localparam logic [5:0] FN_SUB = 6'd1;
    localparam logic [5:0] FN_AND = 6'd2;
    localparam logic [5:0] FN_ORR = 6'd3;
    localparam logic [5:0] FN_NOT = 6'd4;
    localparam logic [5:0] FN_TCP = 6'd5;
    localparam logic [5:0] FN_SHL = 6'd6;
    localparam logic [5:0] FN_SHR = 6'd7;
    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [1:0] REG_DST_RT  = 2'b00;
    localparam logic [1:0] REG_DST_RD  = 2'b01;
    localparam logic [1:0] REG_DST_R2  = 2'b10;

    localparam logic [1:0] ALU_B_RT    = 2'b00;
    localparam logic [1:0] ALU_B_ONE   = 2'b01;
    localparam logic [1:0] ALU_B_IMM   = 2'b10;
    localparam logic [1:0] ALU_B_BOFF  = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RS     = 2'b11;

    typedef struct packed {
        logic is_rtype;
        logic is_imm;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jump;
        logic is_jal;
        logic is_jpr;
        logic is_jrl;
        logic is_wwd;
        logic is_hlt;
    } inst_class_t;

endpackage

// File: rtl/tsc_multicycle_control_inst_decode.sv
// Combinational opcode/funct decode into one-hot instruction-class flags;
// undefined encodings decode to all-zero.
module tsc_inst_decode
    import tsc_multicycle_control_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [5:0]  funct,
    output inst_class_t cls
);

    inst_class_t cls_s;

    // Classify the current instruction
    always_comb begin
        cls_s = '0;
        case (opcode)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: cls_s.is_branch = 1'b1;
            OP_ADI, OP_ORI, OP_LHI:         cls_s.is_imm    = 1'b1;
            OP_LWD:                         cls_s.is_load   = 1'b1;
            OP_SWD:                         cls_s.is_store  = 1'b1;
            OP_JMP:                         cls_s.is_jump   = 1'b1;
            OP_JAL:                         cls_s.is_jal    = 1'b1;
            OP_ALU: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_ORR,
                    FN_NOT, FN_TCP, FN_SHL, FN_SHR: cls_s.is_rtype = 1'b1;
                    FN_JPR:                         cls_s.is_jpr   = 1'b1;
                    FN_JRL:                         cls_s.is_jrl   = 1'b1;
                    FN_WWD:                         cls_s.is_wwd   = 1'b1;
                    FN_HLT:                         cls_s.is_hlt   = 1'b1;
                    default:                        cls_s          = '0;
                endcase
            end
            default: cls_s = '0;
        endcase
    end

    assign cls = cls_s;

endmodule

// File: rtl/tsc_multicycle_control.sv
// Multicycle control FSM for the 16-bit TSC datapath: sequences IF/ID/EX/MEM/WB,
// drives datapath strobes, waits on memory ready, tracks halt and retired count.
module tsc_multicycle_control
    import tsc_multicycle_control_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int NUM_INST_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  input_ready,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic                  i_or_d,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic [1:0]            reg_dst,
    output logic                  alu_op,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_source,
    output logic                  output_port,
    output logic                  is_halted,
    output logic [NUM_INST_W-1:0] num_inst
);

    // The opcode/funct field positions assume the 16-bit TSC instruction word.
    if (WORD_W != 16) begin : g_bad_word_w
        $error("tsc_multicycle_control supports WORD_W == 16 only");
    end

    localparam logic [NUM_INST_W-1:0] INST_ONE = {{(NUM_INST_W-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [NUM_INST_W-1:0]   num_inst_q, num_inst_d;
    logic                    is_halted_q, is_halted_d;
    inst_class_t             cls_s;
    logic                    retire_s;

    tsc_inst_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (cls_s)
    );

    // State, retire counter and halt flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IF;
            num_inst_q  <= '0;
            is_halted_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_inst_q  <= num_inst_d;
            is_halted_q <= is_halted_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (input_ready) state_d = S_ID;
                else             state_d = S_IF;
            end
            S_ID: begin
                if (cls_s.is_hlt)                      state_d = S_HALT;
                else if (cls_s.is_jump || cls_s.is_jal) state_d = S_IF;
                else                                   state_d = S_EX;
            end
            S_EX: begin
                if (cls_s.is_load || cls_s.is_store)     state_d = S_MEM;
                else if (cls_s.is_rtype || cls_s.is_imm) state_d = S_WB;
                else                                     state_d = S_IF;
            end
            S_MEM: begin
                if (!input_ready)       state_d = S_MEM;
                else if (cls_s.is_load) state_d = S_WB;
                else                    state_d = S_IF;
            end
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Retirement is any return to fetch from a later stage; HLT never returns.
    always_comb begin
        retire_s = (state_q != S_IF) && (state_q != S_HALT) && (state_d == S_IF);
        if (retire_s) num_inst_d = num_inst_q + INST_ONE;
        else          num_inst_d = num_inst_q;
        is_halted_d = (state_d == S_HALT);
    end

    // Datapath strobes per state; all forced low while reset is asserted
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = REG_DST_RT;
        alu_op        = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALU_B_RT;
        pc_source     = PC_SRC_ALU;
        output_port   = 1'b0;
        if (reset) begin
            pc_write = 1'b0;
        end else begin
            case (state_q)
                S_IF: begin
                    mem_read = 1'b1;
                    if (input_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_b = ALU_B_ONE;
                        pc_source = PC_SRC_ALU;
                    end else begin
                        ir_write  = 1'b0;
                    end
                end
                S_ID: begin
                    alu_src_b = ALU_B_BOFF;
                    if (cls_s.is_jump || cls_s.is_jal) begin
                        pc_write  = 1'b1;
                        pc_source = PC_SRC_JUMP;
                    end else begin
                        pc_write  = 1'b0;
                    end
                    if (cls_s.is_jal) begin
                        reg_write = 1'b1;
                        reg_dst   = REG_DST_R2;
                    end else begin
                        reg_write = 1'b0;
                    end
                end
                S_EX: begin
                    if (cls_s.is_branch) begin
                        alu_src_a     = 1'b1;
                        pc_write_cond = 1'b1;
                        pc_source     = PC_SRC_ALUOUT;
                    end else if (cls_s.is_imm || cls_s.is_load || cls_s.is_store) begin
                        alu_op    = 1'b1;
                        alu_src_a = 1'b1;
                        alu_src_b = ALU_B_IMM;
                    end else if (cls_s.is_rtype || cls_s.is_wwd || cls_s.is_jpr || cls_s.is_jrl) begin
                        alu_op      = 1'b1;
                        alu_src_a   = 1'b1;
                        output_port = cls_s.is_wwd;
                        pc_write    = cls_s.is_jpr || cls_s.is_jrl;
                        reg_write   = cls_s.is_jrl;
                        if (cls_s.is_jpr || cls_s.is_jrl) pc_source = PC_SRC_RS;
                        else                              pc_source = PC_SRC_ALU;
                        if (cls_s.is_jrl) reg_dst = REG_DST_R2;
                        else              reg_dst = REG_DST_RT;
                    end else begin
                        alu_op = 1'b0;
                    end
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = cls_s.is_load;
                    mem_write = cls_s.is_store;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = cls_s.is_load;
                    if (cls_s.is_rtype) reg_dst = REG_DST_RD;
                    else                reg_dst = REG_DST_RT;
                end
                S_HALT:  pc_write = 1'b0;
                default: pc_write = 1'b0;
            endcase
        end
    end

    assign is_halted = is_halted_q;
    assign num_inst  = num_inst_q;

endmodule

// File: tb/tb_tsc_multicycle_control.sv
// Directed self-checking bench: walks instruction sequences cycle by cycle and
// compares state, the packed strobe vector, retire count and halt flag.
module tb_tsc_multicycle_control;
    import tsc_multicycle_control_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opcode;
    logic [5:0]  funct;
    logic        input_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_write, mem_to_reg, alu_op, alu_src_a, output_port, is_halted;
    logic [1:0]  reg_dst, alu_src_b, pc_source;
    logic [15:0] num_inst;
    logic [16:0] strobes_s;

    int n_tests = 0;
    int n_fail  = 0;

    // Packed as {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //            reg_write, mem_to_reg, reg_dst[1:0], alu_op, alu_src_a,
    //            alu_src_b[1:0], pc_source[1:0], output_port}
    localparam logic [16:0] V_ZERO    = 17'h00000;
    localparam logic [16:0] V_IF_WAIT = 17'h02000;
    localparam logic [16:0] V_IF_GO   = 17'h12808;
    localparam logic [16:0] V_ID      = 17'h00018;
    localparam logic [16:0] V_ID_JAL  = 17'h1051C;
    localparam logic [16:0] V_EX_R    = 17'h00060;
    localparam logic [16:0] V_EX_IMM  = 17'h00070;
    localparam logic [16:0] V_EX_BR   = 17'h08022;
    localparam logic [16:0] V_EX_JPR  = 17'h10066;
    localparam logic [16:0] V_MEM_LD  = 17'h06000;
    localparam logic [16:0] V_MEM_ST  = 17'h05000;
    localparam logic [16:0] V_WB_R    = 17'h00480;
    localparam logic [16:0] V_WB_IMM  = 17'h00400;
    localparam logic [16:0] V_WB_LD   = 17'h00600;

    tsc_multicycle_control #(.WORD_W(16), .NUM_INST_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .input_ready   (input_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .output_port   (output_port),
        .is_halted     (is_halted),
        .num_inst      (num_inst)
    );

    always #5 clk = ~clk;

    assign strobes_s = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                        reg_write, mem_to_reg, reg_dst, alu_op, alu_src_a,
                        alu_src_b, pc_source, output_port};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, then advance past the edge.
    task automatic cyc(input string tag, input logic rst, input logic [3:0] op,
                       input logic [5:0] fn, input logic rdy, input state_t st,
                       input logic [16:0] v, input logic [15:0] n, input logic h);
        reset = rst; opcode = op; funct = fn; input_ready = rdy;
        #1;
        check_eq({tag, ".state"},   32'(dut.state_q), 32'(st));
        check_eq({tag, ".strobes"}, 32'(strobes_s),   32'(v));
        check_eq({tag, ".num_inst"}, 32'(num_inst),   32'(n));
        check_eq({tag, ".halted"},  32'(is_halted),   32'(h));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 4'd0; funct = 6'd0; input_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc("rst0", 1'b1, OP_ALU, FN_ADD, 1'b1, S_IF, V_ZERO, 16'd0, 1'b0);
        cyc("ifw",  1'b0, OP_ALU, FN_ADD, 1'b0, S_IF, V_IF_WAIT, 16'd0, 1'b0);

        cyc("add.if", 1'b0, OP_ALU, FN_ADD, 1'b1, S_IF, V_IF_GO, 16'd0, 1'b0);
        cyc("add.id", 1'b0, OP_ALU, FN_ADD, 1'b1, S_ID, V_ID,    16'd0, 1'b0);
        cyc("add.ex", 1'b0, OP_ALU, FN_ADD, 1'b1, S_EX, V_EX_R,  16'd0, 1'b0);
        cyc("add.wb", 1'b0, OP_ALU, FN_ADD, 1'b1, S_WB, V_WB_R,  16'd0, 1'b0);

        cyc("lwd.if", 1'b0, OP_LWD, 6'd0, 1'b1, S_IF, V_IF_GO,  16'd1, 1'b0);
        cyc("lwd.id", 1'b0, OP_LWD, 6'd0, 1'b0, S_ID, V_ID,     16'd1, 1'b0);
        cyc("lwd.ex", 1'b0, OP_LWD, 6'd0, 1'b0, S_EX, V_EX_IMM, 16'd1, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("lwd.memw", 1'b0, OP_LWD, 6'd0, 1'b0, S_MEM, V_MEM_LD, 16'd1, 1'b0);
        cyc("lwd.mem", 1'b0, OP_LWD, 6'd0, 1'b1, S_MEM, V_MEM_LD, 16'd1, 1'b0);
        cyc("lwd.wb",  1'b0, OP_LWD, 6'd0, 1'b1, S_WB,  V_WB_LD,  16'd1, 1'b0);

        cyc("beq.if", 1'b0, OP_BEQ, 6'd0, 1'b1, S_IF, V_IF_GO, 16'd2, 1'b0);
        cyc("beq.id", 1'b0, OP_BEQ, 6'd0, 1'b0, S_ID, V_ID,    16'd2, 1'b0);
        cyc("beq.ex", 1'b0, OP_BEQ, 6'd0, 1'b1, S_EX, V_EX_BR, 16'd2, 1'b0);

        cyc("jal.if", 1'b0, OP_JAL, 6'd0, 1'b1, S_IF, V_IF_GO,  16'd3, 1'b0);
        cyc("jal.id", 1'b0, OP_JAL, 6'd0, 1'b0, S_ID, V_ID_JAL, 16'd3, 1'b0);

        cyc("jpr.if", 1'b0, OP_ALU, FN_JPR, 1'b1, S_IF, V_IF_GO,  16'd4, 1'b0);
        cyc("jpr.id", 1'b0, OP_ALU, FN_JPR, 1'b0, S_ID, V_ID,     16'd4, 1'b0);
        cyc("jpr.ex", 1'b0, OP_ALU, FN_JPR, 1'b0, S_EX, V_EX_JPR, 16'd4, 1'b0);

        cyc("und.if", 1'b0, 4'd12, 6'd0, 1'b1, S_IF, V_IF_GO, 16'd5, 1'b0);
        cyc("und.id", 1'b0, 4'd12, 6'd0, 1'b0, S_ID, V_ID,    16'd5, 1'b0);
        cyc("und.ex", 1'b0, 4'd12, 6'd0, 1'b0, S_EX, V_ZERO,  16'd5, 1'b0);

        cyc("swd.if",  1'b0, OP_SWD, 6'd0, 1'b1, S_IF,  V_IF_GO,   16'd6, 1'b0);
        cyc("swd.id",  1'b0, OP_SWD, 6'd0, 1'b0, S_ID,  V_ID,      16'd6, 1'b0);
        cyc("swd.ex",  1'b0, OP_SWD, 6'd0, 1'b0, S_EX,  V_EX_IMM,  16'd6, 1'b0);
        cyc("swd.mem", 1'b0, OP_SWD, 6'd0, 1'b0, S_MEM, V_MEM_ST,  16'd6, 1'b0);
        cyc("swd.rst", 1'b1, OP_SWD, 6'd0, 1'b0, S_MEM, V_ZERO,    16'd6, 1'b0);
        cyc("swd.aft", 1'b0, OP_SWD, 6'd0, 1'b0, S_IF,  V_IF_WAIT, 16'd0, 1'b0);

        cyc("adi.if", 1'b0, OP_ADI, 6'd0, 1'b1, S_IF, V_IF_GO,  16'd0, 1'b0);
        cyc("adi.id", 1'b0, OP_ADI, 6'd0, 1'b0, S_ID, V_ID,     16'd0, 1'b0);
        cyc("adi.ex", 1'b0, OP_ADI, 6'd0, 1'b0, S_EX, V_EX_IMM, 16'd0, 1'b0);
        cyc("adi.wb", 1'b0, OP_ADI, 6'd0, 1'b0, S_WB, V_WB_IMM, 16'd0, 1'b0);

        cyc("hlt.if", 1'b0, OP_ALU, FN_HLT, 1'b1, S_IF, V_IF_GO, 16'd1, 1'b0);
        cyc("hlt.id", 1'b0, OP_ALU, FN_HLT, 1'b0, S_ID, V_ID,    16'd1, 1'b0);
        for (int i = 0; i < 20; i++)
            cyc("hlt.hold", 1'b0, OP_ALU, FN_HLT, 1'(i % 2), S_HALT, V_ZERO, 16'd1, 1'b1);
        cyc("hlt.rst", 1'b1, OP_ALU, FN_HLT, 1'b1, S_HALT, V_ZERO,    16'd1, 1'b1);
        cyc("hlt.aft", 1'b0, OP_ALU, FN_HLT, 1'b0, S_IF,   V_IF_WAIT, 16'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
